// File: rtl/lfsr_rng_gen.sv
// -----------------------------------------------------------------------------
// lfsr_rng_gen -- parametrised Fibonacci-LFSR pseudo-random word source.
//
// A WIDTH-bit LFSR (taps in TAP_MASK) is shifted once per enabled cycle. After
// WARMUP discarded shifts, every STEPS-th shift is offered to the consumer as
// one word over a valid/ready handshake. The LFSR keeps free-running while a
// word waits to be taken, so backpressure never stalls the sequence.
//
// Optional feature (define RNG_HEALTH_EN):
//   Repetition-count health test. REP_LIMIT identical consecutive captured
//   words set a sticky health_fail, drop rnd_valid and park the FSM in HALT
//   until reset or seed_load. Without the macro health_fail is tied to 0.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   run the LFSR; low freezes LFSR and counters
//   seed_load    in   single-cycle reseed strobe (a zero seed becomes SEED)
//   seed_in      in   [WIDTH] seed sampled when seed_load=1
//   rnd_valid    out  rnd_data holds an unconsumed word
//   rnd_ready    in   consumer accepts the word
//   rnd_data     out  [WIDTH] random word
//   word_count   out  [32] accepted handshakes, wraps at 2^32
//   busy_warmup  out  FSM is discarding warm-up shifts
//   health_fail  out  sticky health-test failure
// -----------------------------------------------------------------------------
module lfsr_rng_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] TAP_MASK  = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED      = 32'hACE1_BEEF,
    parameter int               STEPS     = 1,
    parameter int               WARMUP    = 16,
    parameter int               REP_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [WIDTH-1:0] rnd_data,
    output logic [31:0]      word_count,
    output logic             busy_warmup,
    output logic             health_fail
);

    localparam int               STEP_W    = $clog2(WIDTH + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [31:0]      WARM_INIT = 32'(WARMUP);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    // With no warm-up the generator comes out of reset/reseed already running.
    localparam state_e ST_START = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    // Elaboration-time parameter legality checks.
    if (WIDTH < 8 || WIDTH > 64) begin : g_chk_width
        $error("lfsr_rng_gen: WIDTH must be in 8..64");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_chk_steps
        $error("lfsr_rng_gen: STEPS must be in 1..WIDTH");
    end
    if (WARMUP < 0) begin : g_chk_warmup
        $error("lfsr_rng_gen: WARMUP must be non-negative");
    end
    if (SEED == '0) begin : g_chk_seed
        $error("lfsr_rng_gen: SEED must be non-zero");
    end
    if (REP_LIMIT < 1) begin : g_chk_rep
        $error("lfsr_rng_gen: REP_LIMIT must be at least 1");
    end

    function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAP_MASK)};
    endfunction

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  lfsr_q, lfsr_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic [WIDTH-1:0]  rnd_data_q, rnd_data_d;
    logic [31:0]       word_count_q, word_count_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [31:0]       warm_cnt_q, warm_cnt_d;

    logic [WIDTH-1:0]  lfsr_next;
    logic              shift_zero;
    logic              accept;
    logic              slot_free;

`ifdef RNG_HEALTH_EN
    // rep_cnt_q = run length of identical words ending in rnd_data_q;
    // 0 means nothing has been captured since reset/reseed.
    logic [31:0]       rep_cnt_q, rep_cnt_d;
    logic [31:0]       rep_next;
    logic              health_fail_q, health_fail_d;
`endif

    always_comb begin
        lfsr_next    = lfsr_shift(lfsr_q);
        shift_zero   = (lfsr_next == '0);
        accept       = rnd_valid_q & rnd_ready;
        slot_free    = ~rnd_valid_q | rnd_ready;

        state_d      = state_q;
        lfsr_d       = lfsr_q;
        rnd_valid_d  = rnd_valid_q;
        rnd_data_d   = rnd_data_q;
        word_count_d = word_count_q;
        step_cnt_d   = step_cnt_q;
        warm_cnt_d   = warm_cnt_q;
`ifdef RNG_HEALTH_EN
        rep_next      = (rep_cnt_q != 32'd0 && lfsr_next == rnd_data_q)
                        ? rep_cnt_q + 32'd1 : 32'd1;
        rep_cnt_d     = rep_cnt_q;
        health_fail_d = health_fail_q;
`endif

        // A transfer always counts and frees the slot, even on a reseed cycle.
        if (accept) begin
            word_count_d = word_count_q + 32'd1;
            rnd_valid_d  = 1'b0;
        end

        if (seed_load) begin
            lfsr_d      = (seed_in == '0) ? SEED : seed_in;
            rnd_valid_d = 1'b0;
            step_cnt_d  = '0;
            warm_cnt_d  = WARM_INIT;
            state_d     = ST_START;
`ifdef RNG_HEALTH_EN
            rep_cnt_d     = 32'd0;
            health_fail_d = 1'b0;
`endif
        end else begin
            // A shift that lands on the all-zero state is a dead cycle: no
            // counter advances and nothing is captured; the following cycle
            // reloads SEED regardless of enable.
            case (state_q)
                ST_WARMUP: begin
                    if (lfsr_q == '0) begin
                        lfsr_d = SEED;
                    end else if (enable) begin
                        lfsr_d = lfsr_next;
                        if (!shift_zero) begin
                            warm_cnt_d = warm_cnt_q - 32'd1;
                            if (warm_cnt_q == 32'd1) begin
                                state_d = ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (lfsr_q == '0) begin
                        lfsr_d = SEED;
                    end else if (enable) begin
                        lfsr_d = lfsr_next;
                        if (!shift_zero) begin
                            if (step_cnt_q != STEP_LAST) begin
                                step_cnt_d = step_cnt_q + STEP_W'(1);
                            end else if (slot_free) begin
                                // Otherwise step_cnt parks at STEP_LAST and the
                                // capture fires on the first cycle the slot frees.
                                step_cnt_d = '0;
`ifdef RNG_HEALTH_EN
                                if (rep_next >= 32'(REP_LIMIT)) begin
                                    health_fail_d = 1'b1;
                                    rnd_valid_d   = 1'b0;
                                    state_d       = ST_HALT;
                                end else begin
                                    rnd_data_d  = lfsr_next;
                                    rnd_valid_d = 1'b1;
                                    rep_cnt_d   = rep_next;
                                end
`else
                                rnd_data_d  = lfsr_next;
                                rnd_valid_d = 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_HALT: begin
                    rnd_valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_START;
            lfsr_q        <= SEED;
            rnd_valid_q   <= 1'b0;
            rnd_data_q    <= '0;
            word_count_q  <= '0;
            step_cnt_q    <= '0;
            warm_cnt_q    <= WARM_INIT;
`ifdef RNG_HEALTH_EN
            rep_cnt_q     <= 32'd0;
            health_fail_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            rnd_valid_q   <= rnd_valid_d;
            rnd_data_q    <= rnd_data_d;
            word_count_q  <= word_count_d;
            step_cnt_q    <= step_cnt_d;
            warm_cnt_q    <= warm_cnt_d;
`ifdef RNG_HEALTH_EN
            rep_cnt_q     <= rep_cnt_d;
            health_fail_q <= health_fail_d;
`endif
        end
    end

    assign rnd_valid   = rnd_valid_q;
    assign rnd_data    = rnd_data_q;
    assign word_count  = word_count_q;
    assign busy_warmup = (state_q == ST_WARMUP);
`ifdef RNG_HEALTH_EN
    assign health_fail = health_fail_q;
`else
    assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// -----------------------------------------------------------------------------
// Directed bench for lfsr_rng_gen. Four instances share clock and reset:
//   A: 32-bit defaults, WARMUP=0, STEPS=1  (first words, reseed, backpressure)
//   B: 32-bit defaults, WARMUP=16, STEPS=1 (warm-up discard)
//   C: 32-bit defaults, WARMUP=0, STEPS=4  (decimation, enable freeze)
//   D: 8-bit, TAP_MASK=0, SEED=1, STEPS=7  (repeating words, health test)
// -----------------------------------------------------------------------------
module tb_lfsr_rng_gen;

`ifdef RNG_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    localparam logic [31:0] SEED32 = 32'hACE1_BEEF;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        en_a, ld_a, rdy_a, v_a, bw_a, hf_a;
    logic [31:0] sd_a, d_a, wc_a;
    logic        en_b, ld_b, rdy_b, v_b, bw_b, hf_b;
    logic [31:0] sd_b, d_b, wc_b;
    logic        en_c, ld_c, rdy_c, v_c, bw_c, hf_c;
    logic [31:0] sd_c, d_c, wc_c;
    logic        en_d, ld_d, rdy_d, v_d, bw_d, hf_d;
    logic [7:0]  sd_d, d_d;
    logic [31:0] wc_d;

    lfsr_rng_gen #(.WARMUP(0), .STEPS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .seed_load(ld_a), .seed_in(sd_a),
        .rnd_valid(v_a), .rnd_ready(rdy_a), .rnd_data(d_a), .word_count(wc_a),
        .busy_warmup(bw_a), .health_fail(hf_a));

    lfsr_rng_gen #(.WARMUP(16), .STEPS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .seed_load(ld_b), .seed_in(sd_b),
        .rnd_valid(v_b), .rnd_ready(rdy_b), .rnd_data(d_b), .word_count(wc_b),
        .busy_warmup(bw_b), .health_fail(hf_b));

    lfsr_rng_gen #(.WARMUP(0), .STEPS(4)) u_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .seed_load(ld_c), .seed_in(sd_c),
        .rnd_valid(v_c), .rnd_ready(rdy_c), .rnd_data(d_c), .word_count(wc_c),
        .busy_warmup(bw_c), .health_fail(hf_c));

    lfsr_rng_gen #(.WIDTH(8), .TAP_MASK(8'h00), .SEED(8'h01), .STEPS(7),
                   .WARMUP(0), .REP_LIMIT(4)) u_d (
        .clk(clk), .rst_n(rst_n), .enable(en_d), .seed_load(ld_d), .seed_in(sd_d),
        .rnd_valid(v_d), .rnd_ready(rdy_d), .rnd_data(d_d), .word_count(wc_d),
        .busy_warmup(bw_d), .health_fail(hf_d));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference shift with the default taps 31, 21, 1, 0.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] ref_nshift(input int n);
        logic [31:0] s;
        s = SEED32;
        for (int i = 0; i < n; i++) s = ref_step(s);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] pat;
        int          s_c, stp_c, acc_c;
        logic        expv, vprev;
        logic        exph;

        rst_n = 1'b0;
        en_a = 0; ld_a = 0; rdy_a = 0; sd_a = '0;
        en_b = 0; ld_b = 0; rdy_b = 0; sd_b = '0;
        en_c = 0; ld_c = 0; rdy_c = 0; sd_c = '0;
        en_d = 0; ld_d = 0; rdy_d = 0; sd_d = '0;

        repeat (2) tick();
        check_eq("rst_valid_a", 64'(v_a), 64'd0);
        check_eq("rst_data_a", 64'(d_a), 64'd0);
        check_eq("rst_count_a", 64'(wc_a), 64'd0);
        check_eq("rst_busy_a", 64'(bw_a), 64'd0);
        check_eq("rst_health_a", 64'(hf_a), 64'd0);
        check_eq("rst_busy_b", 64'(bw_b), 64'd1);
        rst_n = 1'b1;

        // Instance A: first words with rnd_ready held high.
        en_a = 1; rdy_a = 1;
        tick();
        check_eq("a_first_valid", 64'(v_a), 64'd1);
        check_eq("a_first_data", 64'(d_a), 64'h59C3_7DDE);
        check_eq("a_first_count", 64'(wc_a), 64'd0);
        tick();
        check_eq("a_second_data", 64'(d_a), 64'hB386_FBBD);
        check_eq("a_second_count", 64'(wc_a), 64'd1);
        tick();
        check_eq("a_third_data", 64'(d_a), 64'(ref_nshift(3)));
        check_eq("a_third_count", 64'(wc_a), 64'd2);

        // Reseed with zero while a word is pending and accepted in the same cycle.
        ld_a = 1; sd_a = 32'd0;
        tick();
        check_eq("a_reseed_valid", 64'(v_a), 64'd0);
        check_eq("a_reseed_count", 64'(wc_a), 64'd3);
        ld_a = 0; rdy_a = 0;
        tick();
        check_eq("a_restart_valid", 64'(v_a), 64'd1);
        check_eq("a_restart_data", 64'(d_a), 64'h59C3_7DDE);

        // Backpressure: the word must hold while the LFSR free-runs.
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq($sformatf("a_hold_valid_%0d", k), 64'(v_a), 64'd1);
            check_eq($sformatf("a_hold_data_%0d", k), 64'(d_a), 64'h59C3_7DDE);
        end
        check_eq("a_hold_count", 64'(wc_a), 64'd3);
        rdy_a = 1;
        tick();
        check_eq("a_release_data", 64'(d_a), 64'(ref_nshift(7)));
        check_eq("a_release_count", 64'(wc_a), 64'd4);
        en_a = 0;
        tick();
        check_eq("a_disabled_drain_valid", 64'(v_a), 64'd0);
        check_eq("a_disabled_drain_count", 64'(wc_a), 64'd5);

        // Instance B: sixteen discarded shifts, then the 17th is the first word.
        en_b = 1; rdy_b = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq($sformatf("b_warm_valid_%0d", k), 64'(v_b), 64'd0);
            check_eq($sformatf("b_warm_busy_%0d", k), 64'(bw_b), 64'(k < 16));
        end
        tick();
        check_eq("b_first_valid", 64'(v_b), 64'd1);
        check_eq("b_first_data", 64'(d_b), 64'(ref_nshift(17)));
        tick();
        check_eq("b_second_data", 64'(d_b), 64'(ref_nshift(18)));
        en_b = 0;

        // Instance C: one word per four enabled cycles, enable low mid-count.
        rdy_c = 1;
        pat = 15'b111111000111111;
        s_c = 0; stp_c = 0; acc_c = 0; vprev = 1'b0;
        for (int i = 0; i < 15; i++) begin
            en_c = pat[i];
            tick();
            if (vprev) acc_c++;
            expv = 1'b0;
            if (pat[i]) begin
                s_c++;
                stp_c++;
                if (stp_c == 4) begin
                    stp_c = 0;
                    expv = 1'b1;
                end
            end
            check_eq($sformatf("c_valid_%0d", i), 64'(v_c), 64'(expv));
            if (expv) check_eq($sformatf("c_data_%0d", i), 64'(d_c), 64'(ref_nshift(s_c)));
            vprev = expv;
        end
        check_eq("c_count", 64'(wc_c), 64'(acc_c));
        en_c = 0;

        // Instance D: period-9 cycle (8 shifts, one zero-state reload) gives a
        // constant word 8'h80 every 9 cycles with STEPS=7.
        en_d = 1; rdy_d = 1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exph = HEALTH && (e >= 34);
            expv = ((e % 9) == 7) && !exph;
            check_eq($sformatf("d_valid_%0d", e), 64'(v_d), 64'(expv));
            check_eq($sformatf("d_health_%0d", e), 64'(hf_d), 64'(exph));
            if (expv) check_eq($sformatf("d_data_%0d", e), 64'(d_d), 64'h80);
        end
        ld_d = 1; sd_d = 8'h01;
        tick();
        ld_d = 0;
        check_eq("d_reseed_health", 64'(hf_d), 64'd0);
        check_eq("d_reseed_valid", 64'(v_d), 64'd0);
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_eq($sformatf("d_resume_valid_%0d", e), 64'(v_d), 64'(e == 7));
        end
        check_eq("d_resume_data", 64'(d_d), 64'h80);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid_a", 64'(v_a), 64'd0);
        check_eq("arst_data_a", 64'(d_a), 64'd0);
        check_eq("arst_count_a", 64'(wc_a), 64'd0);
        check_eq("arst_valid_b", 64'(v_b), 64'd0);
        check_eq("arst_busy_b", 64'(bw_b), 64'd1);
        check_eq("arst_data_d", 64'(d_d), 64'd0);
        check_eq("arst_health_d", 64'(hf_d), 64'd0);
        #10;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_gen.md
Name: lfsr_rng_gen

Overview:
Parametrised pseudo-random word generator. Successor to the fixed 32-bit LFSR source: generalised width and taps, runtime reseed, warm-up discard, multi-step decimation and a valid/ready output. Sits between the entropy/seed logic and SRAM test/scrambling consumers. Consumers pull one word per handshake.

Parameters:
WIDTH, 32, LFSR and output word width; legal range 8..64.
TAP_MASK, 32'h8020_0003, Fibonacci tap mask; bit i set means lfsr[i] is in the feedback XOR. Default taps are bits 31, 21, 1 and 0.
SEED, 32'hACE1_BEEF, reset seed and replacement for any zero seed; must be non-zero.
STEPS, 1, LFSR shifts per emitted word; legal range 1..WIDTH.
WARMUP, 16, shifts discarded after reset or reseed before the first word; 0 is legal.
REP_LIMIT, 4, identical consecutive words that trip the health test (optional feature only).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run the LFSR; low freezes it
seed_load  in  1  single-cycle reseed strobe
seed_in  in  WIDTH  seed value sampled when seed_load=1
rnd_valid  out  1  rnd_data holds an unconsumed word
rnd_ready  in  1  consumer accepts the word
rnd_data  out  WIDTH  random word
word_count  out  32  accepted handshakes; wraps at 2^32
busy_warmup  out  1  FSM is in WARMUP
health_fail  out  1  sticky health-test failure

Behaviour:
- Reset values: lfsr=SEED, FSM=WARMUP (or RUN if WARMUP=0), rnd_valid=0, rnd_data=0, word_count=0, step_cnt=0, warm_cnt=WARMUP, health_fail=0.
- Feedback: fb = XOR-reduce(lfsr & TAP_MASK). A shift is lfsr <= {lfsr[WIDTH-2:0], fb}.
- FSM states: WARMUP, RUN, HALT.
  - WARMUP: shift one per cycle while enable=1 and decrement warm_cnt. When warm_cnt reaches 0, go to RUN. No words are emitted.
  - RUN: shift every cycle while enable=1 and increment step_cnt. On the shift where step_cnt==STEPS-1, capture the post-shift lfsr into rnd_data, set rnd_valid=1 and clear step_cnt, but only if the slot is free (rnd_valid=0, or rnd_ready=1 in that same cycle).
  - RUN, slot not free: the LFSR keeps free-running and step_cnt saturates at STEPS-1. Capture happens on the first cycle the slot frees.
  - HALT: entered only on health failure. rnd_valid is forced to 0 and the LFSR freezes. Exit only via reset or seed_load.
- enable=0: LFSR, step_cnt and warm_cnt hold. A pending rnd_valid/rnd_data stays and can still be consumed.
- Handshake:
  - A word is transferred when rnd_valid and rnd_ready are both 1 at a rising edge; word_count then increments.
  - While rnd_valid=1 and rnd_ready=0, rnd_data is stable.
  - rnd_valid never drops without a transfer, except on seed_load or HALT.
- seed_load (highest priority after reset, independent of enable):
  - lfsr <= seed_in, or SEED if seed_in==0.
  - rnd_valid <= 0, step_cnt <= 0, warm_cnt <= WARMUP, health_fail <= 0.
  - FSM goes to WARMUP, or to RUN if WARMUP=0.
  - An accept in the same cycle still counts in word_count; the captured word is discarded.
- Zero-state guard: if lfsr==0 is ever observed (e.g. a bad TAP_MASK), reload SEED on the next cycle. No output is produced from the zero state.
- Latency: with WARMUP=0 and STEPS=1, the first rnd_valid appears 1 cycle after enable is first seen high.
- Throughput: one word every STEPS enabled cycles.
- busy_warmup = (FSM==WARMUP).
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Optional Feature:
RNG_HEALTH_EN.
- Defined:
  - Compare each newly captured word with the previous captured word.
  - After REP_LIMIT consecutive identical words, set health_fail=1 (sticky), clear rnd_valid and enter HALT.
  - The failing word is never presented.
- Undefined: no comparator is built, health_fail is tied to 0 and HALT is unreachable.

Test Plan:
1. Reset with WIDTH=32, default SEED and TAP_MASK, WARMUP=0, STEPS=1. Hold rnd_ready=1 and raise enable -> rnd_data=32'h59C37DDE, then 32'hB386FBBD on consecutive cycles; word_count increments every cycle.
2. Backpressure: rnd_ready=0 for 5 cycles with enable=1 -> rnd_data stays 32'h59C37DDE and rnd_valid=1. On release, the next word equals the LFSR state after 6 further shifts (free-run is honoured).
3. WARMUP=16 after reset -> busy_warmup=1 for 16 enabled cycles with no rnd_valid. The first word equals the 17th shift from SEED.
4. seed_load with seed_in=0 while a word is pending -> rnd_valid drops next cycle and lfsr=32'hACE1_BEEF. The output sequence restarts exactly as in scenario 1 (or 3).
5. STEPS=4 with rnd_ready=1 -> rnd_valid pulses every 4th enabled cycle. Each word equals the 4th successive shift; enable=0 mid-count freezes step_cnt.
6. With RNG_HEALTH_EN and TAP_MASK=0, force a constant lfsr via seed -> after REP_LIMIT=4 equal words, health_fail=1 and rnd_valid=0. A subsequent seed_load clears health_fail and resumes.
